// File: rtl/motor_pwm.sv
// motor_pwm: drive-command to dual-wheel PWM with per-period duty ramp.
// Optional macro MOTOR_PWM_RAMP_EN enables ramping; undefined = one-step change.
module motor_pwm #(
    parameter int CNT_W     = 8,
    parameter int DUTY_FWD  = 200,
    parameter int DUTY_FAST = 200,
    parameter int DUTY_SLOW = 60,
    parameter int RAMP_STEP = 50
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [1:0] DRIVER,
    output logic       PWM_L,
    output logic       PWM_R,
    output logic       MOVING
);

    localparam logic [CNT_W-1:0] L_FWD  = CNT_W'(DUTY_FWD);
    localparam logic [CNT_W-1:0] L_FAST = CNT_W'(DUTY_FAST);
    localparam logic [CNT_W-1:0] L_SLOW = CNT_W'(DUTY_SLOW);
    localparam logic [CNT_W-1:0] L_TOP  = {CNT_W{1'b1}};

    logic [1:0]       r_drv_q;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_duty_l;
    logic [CNT_W-1:0] r_duty_r;
    logic             r_pwm_l;
    logic             r_pwm_r;
    logic             r_moving;

    logic             w_wrap;
    logic             w_stop;
    logic [CNT_W-1:0] w_tgt_l;
    logic [CNT_W-1:0] w_tgt_r;
    logic [CNT_W-1:0] w_duty_l_nxt;
    logic [CNT_W-1:0] w_duty_r_nxt;

`ifdef MOTOR_PWM_RAMP_EN
    localparam logic [CNT_W:0] L_STEP = (CNT_W+1)'(RAMP_STEP);

    // Move cur toward tgt by at most one step, never past tgt.
    function automatic logic [CNT_W-1:0] f_ramp(
        input logic [CNT_W-1:0] cur,
        input logic [CNT_W-1:0] tgt
    );
        logic [CNT_W:0] c;
        logic [CNT_W:0] t;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        if (c < t)
            f_ramp = (c + L_STEP >= t) ? tgt : CNT_W'(c + L_STEP);
        else if (c > t)
            f_ramp = (c >= t + L_STEP) ? CNT_W'(c - L_STEP) : tgt;
        else
            f_ramp = cur;
    endfunction
`endif

    assign w_wrap = (r_cnt == L_TOP);
    assign w_stop = (r_drv_q == 2'd0);

    // Decode per-wheel target duty from the captured command.
    always_comb begin
        w_tgt_l = '0;
        w_tgt_r = '0;
        unique case (r_drv_q)
            2'd1: begin
                w_tgt_l = L_FWD;
                w_tgt_r = L_FWD;
            end
            2'd2: begin
                w_tgt_l = L_SLOW;
                w_tgt_r = L_FAST;
            end
            2'd3: begin
                w_tgt_l = L_FAST;
                w_tgt_r = L_SLOW;
            end
            default: begin
                w_tgt_l = '0;
                w_tgt_r = '0;
            end
        endcase
    end

    // Next duty: stop forces zero at once; otherwise change only at a wrap.
    always_comb begin
        w_duty_l_nxt = r_duty_l;
        w_duty_r_nxt = r_duty_r;
        if (w_stop) begin
            w_duty_l_nxt = '0;
            w_duty_r_nxt = '0;
        end else if (w_wrap) begin
`ifdef MOTOR_PWM_RAMP_EN
            w_duty_l_nxt = f_ramp(r_duty_l, w_tgt_l);
            w_duty_r_nxt = f_ramp(r_duty_r, w_tgt_r);
`else
            w_duty_l_nxt = w_tgt_l;
            w_duty_r_nxt = w_tgt_r;
`endif
        end
    end

    // Command capture, counter, duties and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_drv_q  <= '0;
            r_cnt    <= '0;
            r_duty_l <= '0;
            r_duty_r <= '0;
            r_pwm_l  <= 1'b0;
            r_pwm_r  <= 1'b0;
            r_moving <= 1'b0;
        end else begin
            r_drv_q  <= DRIVER;
            r_cnt    <= r_cnt + 1'b1;
            r_duty_l <= w_duty_l_nxt;
            r_duty_r <= w_duty_r_nxt;
            r_pwm_l  <= !w_stop && (r_cnt < r_duty_l);
            r_pwm_r  <= !w_stop && (r_cnt < r_duty_r);
            r_moving <= (w_duty_l_nxt != '0) || (w_duty_r_nxt != '0);
        end
    end

    assign PWM_L  = r_pwm_l;
    assign PWM_R  = r_pwm_r;
    assign MOVING = r_moving;

endmodule
